// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared state encoding and parameter defaults for the gate request controller
package gate_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int DOOR_TIMEOUT_DEF    = 16;
  localparam int REJECT_CYCLES_DEF   = 8;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_REQ_ENTER  = 3'd1;
  localparam logic [2:0] ST_REQ_EXIT   = 3'd2;
  localparam logic [2:0] ST_WAIT_OPEN  = 3'd3;
  localparam logic [2:0] ST_WAIT_CLOSE = 3'd4;
  localparam logic [2:0] ST_REJECT     = 3'd5;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, debouncer and rising-edge event for one push-button
module btn_debounce
  import gate_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [1:0]    vld_q;
  logic          armed_q, armed_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Events are only armed once a released level has been seen after reset,
  // so a button held through reset cannot fire until pressed again.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    armed_d = armed_q | (vld_q[1] & ~sync2_q);
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q & armed_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/gate_request_ctrl.sv
// rtl/gate_request_ctrl.sv - debounced entry/exit button front end issuing gate requests
module gate_request_ctrl
  import gate_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DOOR_TIMEOUT    = DOOR_TIMEOUT_DEF,
  parameter int REJECT_CYCLES   = REJECT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enterBtn,
  input  logic       exitBtn,
  input  logic [1:0] exitSel,
  input  logic       doorOpen,
  input  logic       isFull,
  output logic       enter,
  output logic       exit,
  output logic [1:0] exitLocation,
  output logic       busy,
  output logic       rejectLED
);

  localparam int TW = cnt_width(DOOR_TIMEOUT);
  localparam int RW = cnt_width(REJECT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(DOOR_TIMEOUT - 1);
  localparam logic [RW-1:0] REJ_LAST = RW'(REJECT_CYCLES - 1);

  logic          enter_ev, exit_ev;
  logic          enter_lvl, exit_lvl;
  logic [2:0]    state_q, state_d;
  logic [1:0]    loc_q, loc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] rej_q, rej_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk    (clk),
    .rst    (reset),
    .btn_i  (enterBtn),
    .level_o(enter_lvl),
    .rise_o (enter_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
    .clk    (clk),
    .rst    (reset),
    .btn_i  (exitBtn),
    .level_o(exit_lvl),
    .rise_o (exit_ev)
  );

  // Events are single-cycle and only consumed in IDLE; anything else is dropped.
  always_comb begin
    state_d = state_q;
    loc_d   = loc_q;
    tmo_d   = '0;
    rej_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (exit_ev) begin
          state_d = ST_REQ_EXIT;
          loc_d   = exitSel;
        end else if (enter_ev) begin
          state_d = isFull ? ST_REJECT : ST_REQ_ENTER;
        end
      end
      ST_REQ_ENTER, ST_REQ_EXIT: state_d = ST_WAIT_OPEN;
      ST_WAIT_OPEN: begin
        if (doorOpen) begin
          state_d = ST_WAIT_CLOSE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_WAIT_CLOSE: begin
        if (!doorOpen) state_d = ST_IDLE;
      end
      ST_REJECT: begin
        if (rej_q == REJ_LAST) begin
          state_d = ST_IDLE;
        end else begin
          rej_d = rej_q + RW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      loc_q   <= 2'b00;
      tmo_q   <= '0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      loc_q   <= loc_d;
      tmo_q   <= tmo_d;
      rej_q   <= rej_d;
    end
  end

  assign enter        = (state_q == ST_REQ_ENTER);
  assign exit         = (state_q == ST_REQ_EXIT);
  assign exitLocation = loc_q;
  assign busy         = (state_q != ST_IDLE);
  assign rejectLED    = (state_q == ST_REJECT);

  logic unused_lvl;
  assign unused_lvl = enter_lvl ^ exit_lvl;

endmodule

// File: tb/tb_gate_request_ctrl.sv
// tb/tb_gate_request_ctrl.sv - directed self-checking bench for gate_request_ctrl
module tb_gate_request_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enterBtn, exitBtn, doorOpen, isFull;
  logic [1:0] exitSel;
  logic       enter_s, exit_s, busy_s, rej_s;
  logic [1:0] loc_s;

  int checks = 0;
  int errors = 0;
  int n_enter = 0, n_exit = 0, n_both = 0, n_rej = 0;
  int e0, x0, r0;

  gate_request_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .enterBtn    (enterBtn),
    .exitBtn     (exitBtn),
    .exitSel     (exitSel),
    .doorOpen    (doorOpen),
    .isFull      (isFull),
    .enter       (enter_s),
    .exit        (exit_s),
    .exitLocation(loc_s),
    .busy        (busy_s),
    .rejectLED   (rej_s)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (enter_s) n_enter++;
    if (exit_s) n_exit++;
    if (enter_s && exit_s) n_both++;
    if (rej_s) n_rej++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; enterBtn = 1'b0; exitBtn = 1'b0; doorOpen = 1'b0;
    isFull = 1'b0; exitSel = 2'b00;
    #12;
    chk("rst_enter", enter_s, 0);
    chk("rst_exit", exit_s, 0);
    chk("rst_loc", loc_s, 0);
    chk("rst_busy", busy_s, 0);
    chk("rst_rej", rej_s, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(5);

    // clean press, door cycle
    e0 = n_enter;
    enterBtn = 1'b1;
    tick(6);
    chk("t1_no_early", enter_s, 0);
    tick(1);
    chk("t1_enter", enter_s, 1);
    chk("t1_busy", busy_s, 1);
    tick(1);
    chk("t1_enter_one", enter_s, 0);
    tick(2);
    doorOpen = 1'b1;
    tick(3);
    doorOpen = 1'b0;
    chk("t1_busy_close", busy_s, 1);
    tick(1);
    chk("t1_busy_fall", busy_s, 0);
    chk("t1_enter_cnt", n_enter - e0, 1);
    enterBtn = 1'b0;
    tick(10);

    // bouncing, then steady press that times out
    e0 = n_enter;
    for (int i = 0; i < 10; i++) begin
      enterBtn = (i % 2 == 0);
      tick(2);
    end
    chk("t2_bounce_quiet", n_enter - e0, 0);
    chk("t2_bounce_idle", busy_s, 0);
    enterBtn = 1'b1;
    tick(6);
    chk("t2_no_early", enter_s, 0);
    tick(1);
    chk("t2_enter", enter_s, 1);
    tick(16);
    chk("t2_wait_open_busy", busy_s, 1);
    tick(1);
    chk("t2_timeout_idle", busy_s, 0);
    chk("t2_enter_cnt", n_enter - e0, 1);

    enterBtn = 1'b0;
    tick(10);
    enterBtn = 1'b1;
    tick(7);
    chk("t2_repress", enter_s, 1);
    enterBtn = 1'b0;
    tick(20);
    chk("t2_repress_idle", busy_s, 0);

    // lot full
    isFull = 1'b1;
    e0 = n_enter; r0 = n_rej;
    enterBtn = 1'b1;
    tick(7);
    chk("t3_rej_on", rej_s, 1);
    chk("t3_no_enter", enter_s, 0);
    tick(7);
    chk("t3_rej_last", rej_s, 1);
    tick(1);
    chk("t3_rej_off", rej_s, 0);
    chk("t3_rej_cycles", n_rej - r0, 8);
    chk("t3_enter_cnt", n_enter - e0, 0);
    enterBtn = 1'b0;
    isFull = 1'b0;
    tick(10);

    // simultaneous presses: exit wins
    e0 = n_enter; x0 = n_exit;
    exitSel = 2'b10;
    enterBtn = 1'b1;
    exitBtn = 1'b1;
    tick(7);
    chk("t4_exit", exit_s, 1);
    chk("t4_loc", loc_s, 2);
    chk("t4_no_enter", enter_s, 0);
    tick(1);
    chk("t4_exit_one", exit_s, 0);
    exitSel = 2'b00;
    doorOpen = 1'b1;
    tick(2);
    chk("t4_loc_stable", loc_s, 2);
    chk("t4_busy", busy_s, 1);

    // async reset mid WAIT_CLOSE with exit held
    #2 reset = 1'b1;
    #1;
    chk("t5_busy", busy_s, 0);
    chk("t5_exit", exit_s, 0);
    chk("t5_enter", enter_s, 0);
    chk("t5_loc", loc_s, 0);
    chk("t5_rej", rej_s, 0);
    enterBtn = 1'b0;
    doorOpen = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    tick(20);
    chk("t5_held_no_exit", n_exit - x0, 1);
    chk("t5_held_idle", busy_s, 0);
    exitBtn = 1'b0;
    tick(10);
    exitBtn = 1'b1;
    tick(7);
    chk("t5_repress_exit", exit_s, 1);
    exitBtn = 1'b0;
    tick(20);
    chk("t5_exit_cnt", n_exit - x0, 2);
    chk("t5_enter_cnt", n_enter - e0, 0);
    chk("never_both", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
